si_uart_tx: RTL and testbench

Byte sink for the FIFO simple interface, and the responder on the tx side of the byte controller. It accepts bytes strobed on `rdy_si`, buffers them in a small FIFO, and serialises them as 8N1 UART frames (LSB first) on `tx`. It is the downstream end of the host-loopback/debug path.

---
 rtl/si_pkg.sv | 22 ++
 rtl/si_fifo.sv | 62 ++++++
 rtl/si_uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_si_uart_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/si_pkg.sv
// Shared definitions for the simple-interface byte path and its UART transmitter.
package si_pkg;

    localparam int unsigned SI_DATA_W      = 8;
    localparam int unsigned UART_DATA_BITS = 8;

    typedef logic [SI_DATA_W-1:0] si_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Even parity bit: makes the total count of ones over data+parity even.
    function automatic logic even_parity(input si_byte_t d);
        return ^d;
    endfunction

endpackage

// File: rtl/si_fifo.sv
// Synchronous single-clock FIFO with first-word fall-through read data.
// DEPTH must be a power of two; simultaneous read and write keep the count.
module si_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_rd_data_c,
    output logic                   o_full_c,
    output logic                   o_empty_c,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full_c    = (r_count == CW'(DEPTH));
    assign o_empty_c   = (r_count == '0);
    assign w_do_wr     = i_wr_en & ~o_full_c;
    assign w_do_rd     = i_rd_en & ~o_empty_c;
    assign o_rd_data_c = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    // Storage needs no reset; only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/si_uart_tx.sv
// Byte sink for the FIFO simple interface, serialising bytes as UART frames on tx.
// 8N1 by default; defining SI_UART_TX_PARITY_EN adds an even parity bit (8E1).
module si_uart_tx
    import si_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SI_DATA_W-1:0] data_si,
    input  logic                 rdy_si,
    output logic                 ack_si,
    output logic                 tx,
    output logic                 busy,
    output logic                 overflow
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(FIFO_DEPTH);
    localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [CNT_W-1:0]     w_clk_cnt_nxt;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_nxt;
    si_byte_t             r_shift;
    si_byte_t             w_shift_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
`ifdef SI_UART_TX_PARITY_EN
    logic                 r_parity;
    logic                 w_parity_nxt;
`endif
    logic                 r_ack;
    logic                 r_busy;
    logic                 r_overflow;

    logic                 w_pop;
    logic                 w_bit_done;
    logic                 w_capture;
    si_byte_t             w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [FCNT_W-1:0]    w_fifo_cnt;
    logic [FCNT_W-1:0]    w_fifo_cnt_nxt;

    assign ack_si   = r_ack;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign overflow = r_overflow;

    assign w_capture      = rdy_si & ~r_ack & ~w_fifo_full;
    assign w_bit_done     = (r_clk_cnt == CNT_LAST);
    assign w_fifo_cnt_nxt = w_fifo_cnt + FCNT_W'(w_capture) - FCNT_W'(w_pop);

    si_fifo #(
        .WIDTH (SI_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_capture),
        .i_wr_data   (data_si),
        .i_rd_en     (w_pop),
        .o_rd_data_c (w_fifo_rdata),
        .o_full_c    (w_fifo_full),
        .o_empty_c   (w_fifo_empty),
        .o_count     (w_fifo_cnt)
    );

    // Handshake: ack blocks the source for one cycle after a capture and while full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_ack      <= w_capture | (w_fifo_cnt_nxt == FCNT_FULL);
            r_busy     <= (w_state_nxt != ST_IDLE) | (w_fifo_cnt_nxt != '0);
            r_overflow <= r_overflow | (rdy_si & r_ack);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef SI_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
`ifdef SI_UART_TX_PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
        end
    end

    // tx is registered from w_tx_nxt, so each state sets the level of the next bit-time.
    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
`ifdef SI_UART_TX_PARITY_EN
        w_parity_nxt  = r_parity;
`endif

        if (r_state != ST_IDLE) begin
            w_clk_cnt_nxt = w_bit_done ? '0 : r_clk_cnt + CNT_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_fifo_rdata;
                    w_tx_nxt      = 1'b0;
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = ST_START;
`ifdef SI_UART_TX_PARITY_EN
                    w_parity_nxt  = even_parity(w_fifo_rdata);
`endif
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_idx == BIT_LAST) begin
`ifdef SI_UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[SI_DATA_W-1:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
`ifdef SI_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_done) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_nxt  = w_fifo_rdata;
                        w_tx_nxt     = 1'b0;
                        w_state_nxt  = ST_START;
`ifdef SI_UART_TX_PARITY_EN
                        w_parity_nxt = even_parity(w_fifo_rdata);
`endif
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nxt      = 1'b1;
                w_clk_cnt_nxt = '0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_si_uart_tx.sv
// Scoreboard bench for si_uart_tx: stimulus queues expected bytes, a UART
// receiver model checks every bit-time of every frame on tx.
module tb_si_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef SI_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_si;
    logic       rdy_si;
    logic       ack_si;
    logic       tx;
    logic       busy;
    logic       overflow;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    bit         flush = 1'b0;

    si_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_si  (data_si),
        .rdy_si   (rdy_si),
        .ack_si   (ack_si),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Line level of bit-time k of a frame carrying d: start, 8 data LSB first, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef SI_UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Drive a one-cycle strobe from a negedge; returns at the following negedge.
    task automatic strobe(input logic [7:0] d, input bit accepted);
        rdy_si  = 1'b1;
        data_si = d;
        if (accepted) exp_q.push_back(d);
        @(negedge clk);
        rdy_si  = 1'b0;
        data_si = 8'($urandom);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_busy_low"}, 32'(busy), 0);
    endtask

    task automatic check_gaps(input string name, input int first, input int count);
        check({name, "_frames"}, start_q.size(), first + count);
        if (start_q.size() >= first + count) begin
            for (int i = first + 1; i < first + count; i++)
                check($sformatf("%s_gap%0d", name, i - first), start_q[i] - start_q[i-1], FRAME);
        end
    endtask

    // Receiver: every cycle of every bit-time must hold the expected level.
    initial begin : monitor
        logic [7:0] d;
        bit ok;
        bit aborted;
        forever begin
            @(negedge clk);
            flush = 1'b0;
            if (rst === 1'b0 && tx === 1'b0) begin
                start_q.push_back(cyc);
                check("frame_expected", 32'(exp_q.size() != 0), 1);
                d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                aborted = 1'b0;
                for (int k = 0; k < NB && !aborted; k++) begin
                    ok = 1'b1;
                    for (int c = 0; c < CPB; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (flush) begin
                            aborted = 1'b1;
                            flush   = 1'b0;
                            break;
                        end
                        if (tx !== frame_bit(d, k)) ok = 1'b0;
                    end
                    if (!aborted)
                        check($sformatf("byte%02h_bit%0d", d, k), 32'(ok), 1);
                end
            end
        end
    end

    initial begin : stim
        int c0, s, p, run, maxrun, sent, guard, zeros, nf0, idx;
        logic [7:0] rnd[$];

        rst = 1'b1;
        rdy_si = 1'b0;
        data_si = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_ack", 32'(ack_si), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte from idle.
        c0 = cyc;
        s  = c0 + 2;
        strobe(8'hA5, 1'b1);
        check("single_ack_rise", 32'(ack_si), 1);
        check("single_tx_still_idle", 32'(tx), 1);
        @(negedge clk);
        check("single_ack_one_cycle", 32'(ack_si), 0);
        check("single_tx_fall", 32'(tx), 0);
        check("single_busy", 32'(busy), 1);
        while (cyc < s + FRAME - 1) @(negedge clk);
        check("single_busy_last_stop", 32'(busy), 1);
        @(negedge clk);
        check("single_busy_done", 32'(busy), 0);
        check("single_tx_idle", 32'(tx), 1);
        drain("single", 200);

        // Burst: source strobes whenever ack is low.
        @(negedge clk);
        nf0 = start_q.size();
        sent = 0; run = 0; maxrun = 0; guard = 0;
        while (sent < 6 && guard < 400) begin
            if (ack_si === 1'b1) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (ack_si === 1'b0) begin
                strobe(8'(sent + 1), 1'b1);
                sent++;
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        check("burst_sent", sent, 6);
        check("burst_ack_full_run", maxrun, FRAME - 2 * DEPTH + 1);
        drain("burst", 1000);
        check_gaps("burst", nf0, 6);
        check("burst_overflow", 32'(overflow), 0);

        // Write and pop on the same edge, then fill to full.
        @(negedge clk);
        nf0 = start_q.size();
        c0 = cyc;
        s  = c0 + 2;
        p  = s + FRAME;
        strobe(8'hC0, 1'b1);
        sent = 1; guard = 0;
        while (sent < 4 && guard < 50) begin
            if (ack_si === 1'b0) begin
                strobe(8'hC0 + 8'(sent), 1'b1);
                sent++;
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        check("sim_prefill", sent, 4);
        while (cyc < p - 1) @(negedge clk);
        check("sim_ack_low_before_pop", 32'(ack_si), 0);
        strobe(8'hC4, 1'b1);
        check("sim_ack_after_pushpop", 32'(ack_si), 1);
        @(negedge clk);
        check("sim_ack_released", 32'(ack_si), 0);
        strobe(8'hC5, 1'b1);
        check("sim_ack_full", 32'(ack_si), 1);
        @(negedge clk);
        check("sim_ack_full_hold", 32'(ack_si), 1);
        drain("sim", 1000);
        check_gaps("sim", nf0, 6);

        // Overflow: second strobe lands while ack is high.
        @(negedge clk);
        strobe(8'h11, 1'b1);
        check("ovf_ack_high", 32'(ack_si), 1);
        check("ovf_not_yet", 32'(overflow), 0);
        strobe(8'h22, 1'b0);
        check("ovf_set", 32'(overflow), 1);
        drain("ovf", 300);
        check("ovf_sticky", 32'(overflow), 1);

        // Reset during data bit 3 of 0xFF with two bytes queued.
        @(negedge clk);
        c0 = cyc;
        s  = c0 + 2;
        strobe(8'hFF, 1'b1);
        sent = 1; guard = 0;
        while (sent < 3 && guard < 20) begin
            if (ack_si === 1'b0) begin
                strobe(8'($urandom), 1'b1);
                sent++;
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        while (cyc < s + 4 * CPB + 1) @(negedge clk);
        rst = 1'b1;
        flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", 32'(tx), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ack", 32'(ack_si), 0);
        check("midrst_overflow", 32'(overflow), 0);
        zeros = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
        end
        check("midrst_line_quiet", zeros, 0);

        // Random traffic with random source gaps; leads with parity test bytes.
        rnd.push_back(8'h07);
        rnd.push_back(8'h03);
        for (int i = 0; i < 22; i++) rnd.push_back(8'($urandom));
        idx = 0; guard = 0;
        while (idx < rnd.size() && guard < 4000) begin
            if (ack_si === 1'b0 && $urandom_range(0, 2) == 0) begin
                strobe(rnd[idx], 1'b1);
                idx++;
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        check("rand_all_sent", idx, rnd.size());
        drain("rand", 4000);
        check("rand_overflow", 32'(overflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
